// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word, RAM handshake state and arbiter state types
package cpu_types_pkg;

    localparam int WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    // RAM handshake status reported by the memory each cycle
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Which requester currently owns the single RAM port
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// rtl/mem_arb_perf_cnt.sv - 32-bit saturating event counter with increment enable
module mem_arb_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;

    // Count enabled events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 32'd0;
        end else if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_request_arbiter.sv
// rtl/mem_request_arbiter.sv - fetch/data arbiter onto one RAM port; ARB_PERF_EN adds perf counters
module mem_request_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W        = 32,
    parameter int DATA_PRIORITY = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              merr,
    output logic [31:0]       perf_icnt,
    output logic [31:0]       perf_dcnt,
    output logic [31:0]       perf_stall
);

    arb_state_t state_q, state_d;
    logic       merr_q, merr_d;
    logic       d_pend;

    assign d_pend = dREN | dWEN;

    // Next state, RAM drive and hit strobes decoded from the owner and live requests
    always_comb begin
        state_d  = state_q;
        merr_d   = merr_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = '0;
        dload    = '0;
        case (state_q)
            IDLE: begin
                if (DATA_PRIORITY != 0) begin
                    if (d_pend)    state_d = DACC;
                    else if (iREN) state_d = IACC;
                end else begin
                    if (iREN)        state_d = IACC;
                    else if (d_pend) state_d = DACC;
                end
            end
            DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!d_pend) begin
                    state_d = IDLE;
                end else begin
                    case (ramstate_t'(ramstate))
                        ACCESS: begin
                            dhit    = 1'b1;
                            dload   = ramload;
                            state_d = IDLE;
                        end
                        ERROR: begin
                            merr_d  = 1'b1;
                            state_d = IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            IACC: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    case (ramstate_t'(ramstate))
                        ACCESS: begin
                            ihit    = 1'b1;
                            iload   = ramload;
                            state_d = IDLE;
                        end
                        ERROR: begin
                            merr_d  = 1'b1;
                            state_d = IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Owner register and sticky error flag; reset aborts any access in flight
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            merr_q  <= merr_d;
        end
    end

    assign merr = merr_q;

`ifdef ARB_PERF_EN
    logic stall_inc;

    assign stall_inc = (state_q != IDLE) && !ihit && !dhit;

    mem_arb_perf_cnt u_icnt (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (ihit),
        .count_o (perf_icnt)
    );

    mem_arb_perf_cnt u_dcnt (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (dhit),
        .count_o (perf_dcnt)
    );

    mem_arb_perf_cnt u_stall (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (stall_inc),
        .count_o (perf_stall)
    );
`else
    assign perf_icnt  = 32'd0;
    assign perf_dcnt  = 32'd0;
    assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb/tb_mem_request_arbiter.sv - randomized self-checking bench for mem_request_arbiter
module tb_mem_request_arbiter;
    import cpu_types_pkg::*;

    localparam int W  = 32;
    localparam int DP = 1;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         iREN, dREN, dWEN;
    logic [W-1:0] iaddr, daddr, dstore, ramload;
    logic [1:0]   ramstate;
    logic         ihit, dhit, ramREN, ramWEN, merr;
    logic [W-1:0] iload, dload, ramaddr, ramstore;
    logic [31:0]  perf_icnt, perf_dcnt, perf_stall;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference state
    bit          merr_m;
    int unsigned icnt_m, dcnt_m, stall_m;

    mem_request_arbiter #(.WORD_W(W), .DATA_PRIORITY(DP)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .merr(merr),
        .perf_icnt(perf_icnt), .perf_dcnt(perf_dcnt), .perf_stall(perf_stall)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        merr_m  = 0;
        icnt_m  = 0;
        dcnt_m  = 0;
        stall_m = 0;
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        ramstate = FREE;
    endtask

    // One full access: IDLE request cycle, lat BUSY cycles, then ACCESS or ERROR, then IDLE
    task automatic drive_access(input bit fetch, input bit rd, input bit wr, input int lat,
                                input bit err, input logic [W-1:0] ia, input logic [W-1:0] da,
                                input logic [W-1:0] ds, input logic [W-1:0] ld);
        logic [W-1:0] exp_addr, exp_il, exp_dl;
        bit exp_ren, exp_wen, exp_ih, exp_dh;
        @(posedge CLK); #1;
        iREN = fetch; dREN = rd; dWEN = wr;
        iaddr = ia; daddr = da; dstore = ds;
        ramstate = FREE; ramload = $urandom;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ihit !== 1'b0 || dhit !== 1'b0) begin
            errors++;
            $display("FAIL req_idle: ren=%b wen=%b ihit=%b dhit=%b expected all 0", ramREN, ramWEN, ihit, dhit);
        end
        exp_addr = fetch ? ia : da;
        exp_ren  = fetch ? 1'b1 : (rd && !wr);
        exp_wen  = fetch ? 1'b0 : wr;
        for (int c = 0; c <= lat; c++) begin
            @(posedge CLK); #1;
            ramstate = (c < lat) ? BUSY : (err ? ERROR : ACCESS);
            ramload  = (c < lat) ? $urandom : ld;
            @(negedge CLK);
            checks++;
            if (ramREN !== exp_ren || ramWEN !== exp_wen || ramaddr !== exp_addr) begin
                errors++;
                $display("FAIL ram_drive c%0d: ren=%b wen=%b addr=%h expected ren=%b wen=%b addr=%h",
                         c, ramREN, ramWEN, ramaddr, exp_ren, exp_wen, exp_addr);
            end
            if (!fetch) begin
                checks++;
                if (ramstore !== ds) begin
                    errors++;
                    $display("FAIL ram_store c%0d: got %h expected %h", c, ramstore, ds);
                end
            end
            exp_ih = fetch && (c == lat) && !err;
            exp_dh = !fetch && (c == lat) && !err;
            exp_il = exp_ih ? ld : '0;
            exp_dl = exp_dh ? ld : '0;
            checks++;
            if (ihit !== exp_ih || dhit !== exp_dh || iload !== exp_il || dload !== exp_dl) begin
                errors++;
                $display("FAIL hit c%0d: ihit=%b dhit=%b iload=%h dload=%h expected %b %b %h %h",
                         c, ihit, dhit, iload, dload, exp_ih, exp_dh, exp_il, exp_dl);
            end
        end
        if (err) begin
            merr_m  = 1;
            stall_m += lat + 1;
        end else begin
            stall_m += lat;
            if (fetch) icnt_m++;
            else       dcnt_m++;
        end
        @(posedge CLK); #1;
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ihit !== 1'b0 || dhit !== 1'b0 || merr !== merr_m) begin
            errors++;
            $display("FAIL back_idle: ren=%b wen=%b ihit=%b dhit=%b merr=%b expected 0 0 0 0 merr=%b",
                     ramREN, ramWEN, ihit, dhit, merr, merr_m);
        end
    endtask

    task automatic test_reset();
        nRST = 0;
        iREN = 1; dREN = 1; dWEN = 1;
        iaddr = 32'h40; daddr = 32'h200; dstore = 32'h55;
        ramstate = ACCESS; ramload = 32'hFFFF_FFFF;
        model_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if (ramREN !== 0 || ramWEN !== 0 || ihit !== 0 || dhit !== 0 || merr !== 0 ||
            ramaddr !== 0 || ramstore !== 0 || iload !== 0 || dload !== 0) begin
            errors++;
            $display("FAIL reset_outputs: ren=%b wen=%b ihit=%b dhit=%b merr=%b addr=%h store=%h il=%h dl=%h expected all 0",
                     ramREN, ramWEN, ihit, dhit, merr, ramaddr, ramstore, iload, dload);
        end
        checks++;
        if (perf_icnt !== 0 || perf_dcnt !== 0 || perf_stall !== 0) begin
            errors++;
            $display("FAIL reset_perf: %0d %0d %0d expected 0 0 0", perf_icnt, perf_dcnt, perf_stall);
        end
        idle_inputs();
        @(negedge CLK);
        nRST = 1;
    endtask

    task automatic test_data_read();
        drive_access(0, 1, 0, 2, 0, 32'h0, 32'h100, 32'h0, 32'hDEAD_BEEF);
    endtask

    task automatic test_fetch_and_write();
        drive_access(1, 0, 0, 1, 0, 32'h40, 32'h0, 32'h0, 32'h1234_5678);
        drive_access(0, 0, 1, 0, 0, 32'h0, 32'h200, 32'h55, 32'h0);
        drive_access(0, 1, 1, 1, 0, 32'h0, 32'h300, 32'hA5A5, 32'h0);
    endtask

    // Both pending: winner completes, IDLE gap, then loser is serviced
    task automatic test_priority();
        bit first_data;
        first_data = (DP != 0);
        @(posedge CLK); #1;
        iREN = 1; iaddr = 32'h40;
        dWEN = 1; dREN = 0; daddr = 32'h200; dstore = 32'h55;
        ramstate = FREE;
        for (int a = 0; a < 2; a++) begin
            bit is_data;
            is_data = (a == 0) ? first_data : !first_data;
            for (int c = 0; c < 2; c++) begin
                @(posedge CLK); #1;
                ramstate = (c == 0) ? BUSY : ACCESS;
                ramload  = 32'hC0DE_0000 + a;
                @(negedge CLK);
                checks++;
                if (ramaddr !== (is_data ? 32'h200 : 32'h40) || ramWEN !== is_data || ramREN !== !is_data) begin
                    errors++;
                    $display("FAIL prio_drive a%0d c%0d: addr=%h wen=%b ren=%b expected data=%b", a, c, ramaddr, ramWEN, ramREN, is_data);
                end
                checks++;
                if (ihit !== (c == 1 && !is_data) || dhit !== (c == 1 && is_data) || (ihit && dhit)) begin
                    errors++;
                    $display("FAIL prio_hit a%0d c%0d: ihit=%b dhit=%b expected data=%b at c1", a, c, ihit, dhit, is_data);
                end
            end
            stall_m++;
            if (is_data) dcnt_m++; else icnt_m++;
            @(posedge CLK); #1;
            if (is_data) dWEN = 0; else iREN = 0;
            ramstate = FREE;
            @(negedge CLK);
            checks++;
            if (ramREN !== 0 || ramWEN !== 0 || ihit !== 0 || dhit !== 0) begin
                errors++;
                $display("FAIL prio_gap a%0d: ren=%b wen=%b ihit=%b dhit=%b expected 0", a, ramREN, ramWEN, ihit, dhit);
            end
        end
        idle_inputs();
    endtask

    task automatic test_error();
        drive_access(1, 0, 0, 1, 1, 32'h80, 32'h0, 32'h0, 32'hBAD0_BAD0);
        drive_access(0, 1, 0, 0, 0, 32'h0, 32'h104, 32'h0, 32'h0000_1111);
    endtask

    task automatic test_abort();
        @(posedge CLK); #1;
        iREN = 1; iaddr = 32'h44; ramstate = FREE;
        @(posedge CLK); #1;
        ramstate = BUSY;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1 || ramaddr !== 32'h44) begin
            errors++;
            $display("FAIL abort_enter: ren=%b addr=%h expected 1 00000044", ramREN, ramaddr);
        end
        @(posedge CLK); #1;
        iREN = 0; ramstate = ACCESS; ramload = 32'h7777_7777;
        @(negedge CLK);
        checks++;
        if (ihit !== 0 || iload !== 0) begin
            errors++;
            $display("FAIL abort_nohit: ihit=%b iload=%h expected 0 0", ihit, iload);
        end
        stall_m += 2;
        @(posedge CLK); #1;
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (ramREN !== 0 || ihit !== 0) begin
            errors++;
            $display("FAIL abort_idle: ren=%b ihit=%b expected 0 0", ramREN, ihit);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge CLK); #1;
        dREN = 1; daddr = 32'h108; ramstate = FREE;
        @(posedge CLK); #1;
        ramstate = BUSY;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1) begin
            errors++;
            $display("FAIL rstmid_enter: ren=%b expected 1", ramREN);
        end
        #1 nRST = 0;
        ramstate = ACCESS;
        #1;
        checks++;
        if (ramREN !== 0 || ramWEN !== 0 || dhit !== 0 || merr !== 0) begin
            errors++;
            $display("FAIL rstmid_drop: ren=%b wen=%b dhit=%b merr=%b expected 0 0 0 0", ramREN, ramWEN, dhit, merr);
        end
        model_reset();
        @(negedge CLK);
        idle_inputs();
        nRST = 1;
        @(negedge CLK);
        checks++;
        if (ramREN !== 0 || dhit !== 0) begin
            errors++;
            $display("FAIL rstmid_idle: ren=%b dhit=%b expected 0 0", ramREN, dhit);
        end
    endtask

    task automatic test_perf();
        logic [31:0] ei, ed, es;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive_access(1, 0, 0, 1, 0, 32'h400 + 4 * k, 32'h0, 32'h0, $urandom);
            else       drive_access(0, 1, 0, 1, 0, 32'h0, 32'h800 + 4 * k, 32'h0, $urandom);
        end
`ifdef ARB_PERF_EN
        ei = icnt_m; ed = dcnt_m; es = stall_m;
`else
        ei = 0; ed = 0; es = 0;
`endif
        checks++;
        if (perf_icnt !== ei || perf_dcnt !== ed || perf_stall !== es) begin
            errors++;
            $display("FAIL perf_counts: icnt=%0d dcnt=%0d stall=%0d expected %0d %0d %0d",
                     perf_icnt, perf_dcnt, perf_stall, ei, ed, es);
        end
    endtask

    task automatic test_random();
        logic [31:0] ei, ed, es;
        for (int t = 0; t < 25; t++) begin
            int kind;
            kind = $urandom_range(0, 3);
            drive_access(kind == 3, kind == 0 || kind == 2, kind == 1 || kind == 2,
                         $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                         $urandom, $urandom, $urandom, $urandom);
        end
`ifdef ARB_PERF_EN
        ei = icnt_m; ed = dcnt_m; es = stall_m;
`else
        ei = 0; ed = 0; es = 0;
`endif
        checks++;
        if (perf_icnt !== ei || perf_dcnt !== ed || perf_stall !== es) begin
            errors++;
            $display("FAIL random_perf: icnt=%0d dcnt=%0d stall=%0d expected %0d %0d %0d",
                     perf_icnt, perf_dcnt, perf_stall, ei, ed, es);
        end
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_fetch_and_write();
        test_priority();
        test_error();
        test_abort();
        test_reset_mid();
        test_perf();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
